ps2_keypad_rx: RTL and testbench
================================

# ps2_keypad_rx

Parametrised PS/2 keyboard receiver and digit-entry accumulator; successor to the fixed 4-digit keyboard decoder. It synchronises and debounces PS2Clk/PS2Data and deserialises 11-bit frames with full start/stop/odd-parity checking. It tracks make/break/extended prefixes and collects NUM_DIGITS decimal digits, with backspace and escape editing, into a stable output word. It sits between the board PS/2 pins and the game FSM, which consumes `userInt` on `ready`.

## Interface
- NUM_DIGITS, 4, digits per entry (1..8); `userInt` width is 4*NUM_DIGITS
- DB_CYCLES, 256, consecutive stable samples required by each debouncer (>=2)
- TIMEOUT_CYCLES, 100000, idle clk cycles mid-frame before the bit counter is abandoned (>=16)

- clk  in  1  system clock, all logic on posedge
- rst  in  1  synchronous, active-high reset
- PS2Clk  in  1  raw PS/2 clock pin (asynchronous)
- PS2Data  in  1  raw PS/2 data pin (asynchronous)
- ready  out  1  one-cycle pulse: `userInt` just updated with a complete entry
- userInt  out  4*NUM_DIGITS  completed entry; first-typed digit in [3:0]
- digit_count  out  4  digits currently held in the in-progress entry
- scan_valid  out  1  one-cycle pulse: a frame passed all checks
- scan_code  out  8  last valid scan byte, held
- frame_err  out  1  one-cycle pulse: bad start, stop or parity, or timeout

## Operation
- Input path per pin: 2-FF synchroniser, then debouncer. The debounced output follows the input only after DB_CYCLES consecutive equal samples. Debounced outputs reset to 1 (idle bus).
- Falling edge = previous debounced clock 1, current 0. On each edge, shift the debounced data into an 11-bit frame register at bit index `bitcnt` (0..10), LSB first.
- After bit 10 is stored: bit0 must be 0, bit10 must be 1, and bits[9:1] must have odd parity. Pass -> `scan_code` <= bits[8:1], pulse `scan_valid`. Fail -> pulse `frame_err`, byte discarded. `bitcnt` returns to 0 either way.
- Timeout: `bitcnt`≠0 and no falling edge for TIMEOUT_CYCLES -> `bitcnt` <= 0, pulse `frame_err`. A falling edge in the same cycle as expiry wins, and the timer restarts.
- Decoder FSM acts on valid bytes only. States: IDLE, BRK, EXT, EXT_BRK.
  - IDLE: F0 -> BRK; E0 -> EXT; otherwise act on make code, stay IDLE.
  - BRK: any byte -> IDLE, byte ignored (key release).
  - EXT: F0 -> EXT_BRK; any other byte -> IDLE, ignored.
  - EXT_BRK: any byte -> IDLE, ignored.
  - `frame_err` does not change FSM state.
- Make-code actions in IDLE:
  - 16,1E,26,25,2E,36,3D,3E,46,45 = digits 1..9,0. Write into nibble `digit_count` of the internal buffer, `digit_count`+1.
  - 66 (backspace): if `digit_count`>0, decrement and zero that nibble; else no-op.
  - 76 (escape): clear buffer, `digit_count` <= 0.
  - All other codes: ignored.
- Completion: when a digit fills the last nibble, `userInt` <= buffer including the new digit, `ready` pulses, and the buffer and `digit_count` clear. `userInt` holds its value until the next completion or reset.

## Timing
- Reset values: `ready`=0, `userInt`=0, `digit_count`=0, `scan_valid`=0, `scan_code`=0, `frame_err`=0, `bitcnt`=0, FSM=IDLE, timer=0, buffer=0.
- Edge detect latency from a raw pin change: 2 (sync) + DB_CYCLES + 1 cycles.
- Cycle E: the edge that stores bit 10.
  - E+1: frame check; `scan_valid`/`frame_err` pulse, `scan_code` updated.
  - E+2: FSM transition and digit action. On completion, `userInt`, `ready` and the `digit_count` clear all take effect in this cycle.
- Every pulse output is high for exactly one clk.
- `rst` asserted in any cycle overrides all activity, including a frame in flight. A partial frame is discarded and no pulse is produced in that cycle.
- `digit_count` never exceeds NUM_DIGITS-1 as observed at the output.

## Test plan
- Reset, then idle pins high for 10k cycles -> all outputs 0, no pulses.
- Type make 16,1E,26,25, each followed by F0 + the same code (NUM_DIGITS=4) -> one `ready` pulse, `userInt`=16'h4321, `digit_count` back to 0. Exactly 4 digit actions occur; break bytes are ignored.
- Frame for 0x16 with parity bit flipped -> `frame_err` pulse at E+1, no `scan_valid`, `digit_count` unchanged. The next good 0x16 -> `digit_count`=1.
- Keys 1, 2, backspace (66), 3, 4, 5 -> `userInt`=16'h5431. Escape (76) after two digits -> `digit_count`=0.
- Send 5 bits and stop; wait TIMEOUT_CYCLES -> single `frame_err` pulse, `bitcnt`=0. A following full 0x45 frame decodes as digit 0.
- E0 75 then E0 F0 75 (extended arrow) -> `scan_valid` pulses, no digit change, FSM ends in IDLE. Assert `rst` between edges 6 and 7 of a frame -> all outputs 0, and the next full frame decodes correctly.

Source files
------------

// File: rtl/ps2_keypad_rx_if.sv
// Output bundle of the PS/2 keypad receiver towards the game FSM.
// Latency: none, plain wiring of registered receiver outputs.
// Backpressure: none, every field is a pulse or a held value.
interface ps2_keypad_rx_if #(
  parameter int NUM_DIGITS = 4
);
  logic                    ready;
  logic [4*NUM_DIGITS-1:0] userInt;
  logic [3:0]              digit_count;
  logic                    scan_valid;
  logic [7:0]              scan_code;
  logic                    frame_err;

  // Receiver drives the bundle.
  modport master (
    output ready, userInt, digit_count, scan_valid, scan_code, frame_err
  );

  // Consumer (game FSM or bench) observes the bundle.
  modport slave (
    input ready, userInt, digit_count, scan_valid, scan_code, frame_err
  );
endinterface

// File: rtl/ps2_keypad_rx.sv
// PS/2 keyboard receiver: sync + debounce pins, deframe 11-bit words, decode digit entry.
// Latency: pin change -> edge 2+DB_CYCLES+1 clk; scan_valid/frame_err at E+1, ready at E+2.
// Backpressure: none; pulses are one clk wide and the consumer must sample them.
module ps2_keypad_rx #(
  parameter int NUM_DIGITS     = 4,
  parameter int DB_CYCLES      = 256,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             PS2Clk,
  input  logic             PS2Data,
  ps2_keypad_rx_if.master  out_if
);

  localparam int              UW      = 4 * NUM_DIGITS;
  localparam int              DBW     = $clog2(DB_CYCLES);
  localparam int              TOW     = $clog2(TIMEOUT_CYCLES);
  localparam logic [DBW-1:0]  DB_LAST = DBW'(DB_CYCLES - 1);
  localparam logic [TOW-1:0]  TO_LAST = TOW'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]      LAST_IX = 4'(NUM_DIGITS - 1);

  typedef enum logic [1:0] {S_IDLE, S_BRK, S_EXT, S_EXT_BRK} state_t;

  // Index 0 carries the PS/2 clock pin, index 1 the data pin.
  logic [1:0]     sync1_q, sync2_q, deb_q;
  logic [DBW-1:0] db_cnt_q [2];

  logic           clk_prev_q;
  logic [3:0]     bitcnt_q;
  logic [9:0]     frame_q;
  logic [TOW-1:0] timer_q;
  logic           scan_valid_q, frame_err_q;
  logic [7:0]     scan_code_q;

  state_t         state_q;
  logic [UW-1:0]  buf_q, user_q;
  logic [3:0]     digit_count_q;
  logic           ready_q;

  logic           fall_w, frame_ok_w;
  logic [10:0]    frame_full_w;
  logic [4:0]     digit_w;
  logic [3:0]     bs_idx_w;
  logic [UW-1:0]  buf_ins_w, buf_bs_w;

  // Make code -> {is_digit, value}; the top row 1..9,0.
  function automatic logic [4:0] digit_lookup(input logic [7:0] code);
    case (code)
      8'h16:   digit_lookup = {1'b1, 4'd1};
      8'h1E:   digit_lookup = {1'b1, 4'd2};
      8'h26:   digit_lookup = {1'b1, 4'd3};
      8'h25:   digit_lookup = {1'b1, 4'd4};
      8'h2E:   digit_lookup = {1'b1, 4'd5};
      8'h36:   digit_lookup = {1'b1, 4'd6};
      8'h3D:   digit_lookup = {1'b1, 4'd7};
      8'h3E:   digit_lookup = {1'b1, 4'd8};
      8'h46:   digit_lookup = {1'b1, 4'd9};
      8'h45:   digit_lookup = {1'b1, 4'd0};
      default: digit_lookup = 5'd0;
    endcase
  endfunction

  // Two-flop synchronisers for both pins; idle bus level is 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 2'b11;
      sync2_q <= 2'b11;
    end else begin
      sync1_q <= {PS2Data, PS2Clk};
      sync2_q <= sync1_q;
    end
  end

  // Debouncers: output adopts the input after DB_CYCLES consecutive differing samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      deb_q <= 2'b11;
      for (int i = 0; i < 2; i++) db_cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (sync2_q[i] == deb_q[i]) begin
          db_cnt_q[i] <= '0;
        end else if (db_cnt_q[i] == DB_LAST) begin
          deb_q[i]    <= sync2_q[i];
          db_cnt_q[i] <= '0;
        end else begin
          db_cnt_q[i] <= db_cnt_q[i] + 1'b1;
        end
      end
    end
  end

  // The frame is checked on the edge that delivers bit 10, so the stop bit comes straight from the pin.
  assign fall_w       = clk_prev_q & ~deb_q[0];
  assign frame_full_w = {deb_q[1], frame_q};
  assign frame_ok_w   = ~frame_full_w[0] & frame_full_w[10] & (^frame_full_w[9:1]);

  // Deframer with idle timeout; a falling edge always beats timer expiry.
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_prev_q   <= 1'b1;
      bitcnt_q     <= '0;
      frame_q      <= '0;
      timer_q      <= '0;
      scan_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      scan_code_q  <= '0;
    end else begin
      clk_prev_q   <= deb_q[0];
      scan_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      if (fall_w) begin
        timer_q <= '0;
        if (bitcnt_q == 4'd10) begin
          bitcnt_q <= '0;
          if (frame_ok_w) begin
            scan_valid_q <= 1'b1;
            scan_code_q  <= frame_full_w[8:1];
          end else begin
            frame_err_q <= 1'b1;
          end
        end else begin
          frame_q[bitcnt_q] <= deb_q[1];
          bitcnt_q          <= bitcnt_q + 4'd1;
        end
      end else if (bitcnt_q != 4'd0) begin
        if (timer_q == TO_LAST) begin
          bitcnt_q    <= '0;
          timer_q     <= '0;
          frame_err_q <= 1'b1;
        end else begin
          timer_q <= timer_q + 1'b1;
        end
      end else begin
        timer_q <= '0;
      end
    end
  end

  // Candidate buffers for a digit insert and for a backspace.
  always_comb begin
    digit_w   = digit_lookup(scan_code_q);
    bs_idx_w  = digit_count_q - 4'd1;
    buf_ins_w = buf_q;
    buf_ins_w[digit_count_q*4 +: 4] = digit_w[3:0];
    buf_bs_w  = buf_q;
    buf_bs_w[bs_idx_w*4 +: 4] = 4'd0;
  end

  // Prefix-tracking decoder and digit accumulator, acting one cycle after scan_valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      buf_q         <= '0;
      user_q        <= '0;
      digit_count_q <= '0;
      ready_q       <= 1'b0;
    end else begin
      ready_q <= 1'b0;
      if (scan_valid_q) begin
        case (state_q)
          S_IDLE: begin
            if (scan_code_q == 8'hF0) begin
              state_q <= S_BRK;
            end else if (scan_code_q == 8'hE0) begin
              state_q <= S_EXT;
            end else if (digit_w[4]) begin
              if (digit_count_q == LAST_IX) begin
                user_q        <= buf_ins_w;
                ready_q       <= 1'b1;
                buf_q         <= '0;
                digit_count_q <= '0;
              end else begin
                buf_q         <= buf_ins_w;
                digit_count_q <= digit_count_q + 4'd1;
              end
            end else if (scan_code_q == 8'h66) begin
              if (digit_count_q != 4'd0) begin
                buf_q         <= buf_bs_w;
                digit_count_q <= bs_idx_w;
              end
            end else if (scan_code_q == 8'h76) begin
              buf_q         <= '0;
              digit_count_q <= '0;
            end
          end
          S_EXT:   state_q <= (scan_code_q == 8'hF0) ? S_EXT_BRK : S_IDLE;
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign out_if.ready       = ready_q;
  assign out_if.userInt     = user_q;
  assign out_if.digit_count = digit_count_q;
  assign out_if.scan_valid  = scan_valid_q;
  assign out_if.scan_code   = scan_code_q;
  assign out_if.frame_err   = frame_err_q;

endmodule

// File: tb/tb_ps2_keypad_rx.sv
// Bench for ps2_keypad_rx: directed keystroke sequences plus random frames vs a keystroke-level model.
// Latency: expectations are queued at send time and popped whenever the DUT pulses.
// Backpressure: none; the monitor samples every pulse on the falling clock edge.
module tb_ps2_keypad_rx;
  localparam int ND   = 4;
  localparam int DB   = 4;
  localparam int TO   = 200;
  localparam int HALF = 12;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic PS2Clk = 1'b1;
  logic PS2Data = 1'b1;

  always #5 clk = ~clk;

  ps2_keypad_rx_if #(.NUM_DIGITS(ND)) out_if ();

  ps2_keypad_rx #(.NUM_DIGITS(ND), .DB_CYCLES(DB), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .PS2Clk(PS2Clk), .PS2Data(PS2Data), .out_if(out_if)
  );

  int total = 0;
  int bad = 0;

  // Scoreboard state.
  logic [7:0]  exp_scan[$];
  logic [15:0] exp_user[$];
  int          exp_err = 0;

  // Keystroke-level model: typed digits, pending prefix flags, last completed word.
  int          digits[$];
  bit          ign_next = 0;
  bit          ext_pend = 0;
  logic [15:0] last_user = 16'h0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic int digit_of(input logic [7:0] b);
    case (b)
      8'h16: return 1; 8'h1E: return 2; 8'h26: return 3; 8'h25: return 4;
      8'h2E: return 5; 8'h36: return 6; 8'h3D: return 7; 8'h3E: return 8;
      8'h46: return 9; 8'h45: return 0;
      default: return -1;
    endcase
  endfunction

  task automatic model_reset();
    digits.delete();
    ign_next  = 0;
    ext_pend  = 0;
    last_user = 16'h0;
  endtask

  // A byte after E0 or F0 is swallowed; E0 F0 swallows one more.
  task automatic model_byte(input logic [7:0] b);
    int d;
    logic [15:0] w;
    if (ext_pend) begin
      ext_pend = 0;
      if (b == 8'hF0) ign_next = 1;
    end else if (ign_next) begin
      ign_next = 0;
    end else if (b == 8'hF0) begin
      ign_next = 1;
    end else if (b == 8'hE0) begin
      ext_pend = 1;
    end else begin
      d = digit_of(b);
      if (d >= 0) begin
        digits.push_back(d);
        if (digits.size() == ND) begin
          w = 16'h0;
          for (int i = 0; i < ND; i++) w = w + 16'(digits[i] << (4 * i));
          exp_user.push_back(w);
          last_user = w;
          digits.delete();
        end
      end else if (b == 8'h66) begin
        if (digits.size() > 0) void'(digits.pop_back());
      end else if (b == 8'h76) begin
        digits.delete();
      end
    end
  endtask

  task automatic send_bit(input logic b);
    PS2Data = b;
    cyc(HALF);
    PS2Clk = 1'b0;
    cyc(HALF);
    PS2Clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par);
    logic [10:0] f;
    f = {1'b1, (~^b) ^ bad_par, b, 1'b0};
    if (bad_par) begin
      exp_err++;
    end else begin
      exp_scan.push_back(b);
      model_byte(b);
    end
    for (int i = 0; i < 11; i++) send_bit(f[i]);
    PS2Data = 1'b1;
    cyc(40);
  endtask

  task automatic check_state(input string tag);
    check({tag, "_digit_count"}, 32'(out_if.digit_count), 32'(digits.size()));
    check({tag, "_userInt"}, 32'(out_if.userInt), 32'(last_user));
  endtask

  // Monitor: every pulse must match the head of its expectation queue.
  always @(negedge clk) begin
    if (rst) begin
      if (out_if.scan_valid || out_if.ready || out_if.frame_err) begin
        total++;
        bad++;
        $display("FAIL pulse_during_reset: got sv=%0b rdy=%0b err=%0b expected 0",
                 out_if.scan_valid, out_if.ready, out_if.frame_err);
      end
    end else begin
      if (out_if.scan_valid) begin
        if (exp_scan.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_scan_valid: got %0h expected none", out_if.scan_code);
        end else begin
          check("scan_code", 32'(out_if.scan_code), 32'(exp_scan.pop_front()));
        end
      end
      if (out_if.ready) begin
        if (exp_user.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_ready: got %0h expected none", out_if.userInt);
        end else begin
          check("ready_userInt", 32'(out_if.userInt), 32'(exp_user.pop_front()));
          check("ready_count_clear", 32'(out_if.digit_count), 32'd0);
        end
      end
      if (out_if.frame_err) begin
        check("frame_err_expected", 32'(exp_err > 0), 32'd1);
        if (exp_err > 0) exp_err--;
      end
    end
  end

  initial begin
    logic [7:0] keys[4];
    logic [7:0] dcodes[10];
    logic [7:0] b;
    int r;
    keys   = '{8'h16, 8'h1E, 8'h26, 8'h25};
    dcodes = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46, 8'h45};

    // Reset state.
    rst = 1'b1;
    cyc(5);
    check("rst_ready", 32'(out_if.ready), 32'd0);
    check("rst_userInt", 32'(out_if.userInt), 32'd0);
    check("rst_digit_count", 32'(out_if.digit_count), 32'd0);
    check("rst_scan_valid", 32'(out_if.scan_valid), 32'd0);
    check("rst_scan_code", 32'(out_if.scan_code), 32'd0);
    check("rst_frame_err", 32'(out_if.frame_err), 32'd0);
    rst = 1'b0;

    // Long idle bus: nothing may happen.
    cyc(10000);
    check("idle_userInt", 32'(out_if.userInt), 32'd0);
    check("idle_digit_count", 32'(out_if.digit_count), 32'd0);
    check("idle_scan_code", 32'(out_if.scan_code), 32'd0);

    // Four digits with break codes in between.
    for (int i = 0; i < 4; i++) begin
      send_frame(keys[i], 0);
      send_frame(8'hF0, 0);
      send_frame(keys[i], 0);
    end
    check("entry_4321", 32'(out_if.userInt), 32'h4321);
    check("entry_count", 32'(out_if.digit_count), 32'd0);

    // Corrupted parity leaves the entry untouched; the retry counts.
    send_frame(8'h16, 1);
    check("parity_err_count", 32'(out_if.digit_count), 32'd0);
    send_frame(8'h16, 0);
    check("after_retry_count", 32'(out_if.digit_count), 32'd1);
    send_frame(8'h76, 0);

    // Backspace and escape editing.
    send_frame(8'h16, 0);
    send_frame(8'h1E, 0);
    send_frame(8'h66, 0);
    check("backspace_count", 32'(out_if.digit_count), 32'd1);
    send_frame(8'h26, 0);
    send_frame(8'h25, 0);
    send_frame(8'h2E, 0);
    check("entry_5431", 32'(out_if.userInt), 32'h5431);
    send_frame(8'h66, 0);
    check("backspace_empty", 32'(out_if.digit_count), 32'd0);
    send_frame(8'h16, 0);
    send_frame(8'h1E, 0);
    send_frame(8'h76, 0);
    check("escape_count", 32'(out_if.digit_count), 32'd0);

    // Truncated frame must time out once; the next frame decodes normally.
    exp_err++;
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    PS2Data = 1'b1;
    cyc(TO + 100);
    check("timeout_err_seen", 32'(exp_err), 32'd0);
    send_frame(8'h45, 0);
    check("post_timeout_count", 32'(out_if.digit_count), 32'd1);
    check_state("post_timeout");

    // Extended arrow make and break: no digit change, decoder back in idle.
    send_frame(8'hE0, 0);
    send_frame(8'h75, 0);
    send_frame(8'hE0, 0);
    send_frame(8'hF0, 0);
    send_frame(8'h75, 0);
    check("ext_count", 32'(out_if.digit_count), 32'd1);
    send_frame(8'h16, 0);
    check("ext_then_make", 32'(out_if.digit_count), 32'd2);

    // Reset between edges 6 and 7 of a frame.
    for (int i = 0; i < 6; i++) send_bit(i == 0 ? 1'b0 : 1'b1);
    PS2Data = 1'b1;
    cyc(2);
    rst = 1'b1;
    model_reset();
    cyc(5);
    rst = 1'b0;
    cyc(2);
    check("midrst_userInt", 32'(out_if.userInt), 32'd0);
    check("midrst_count", 32'(out_if.digit_count), 32'd0);
    check("midrst_scan_code", 32'(out_if.scan_code), 32'd0);
    send_frame(8'h1E, 0);
    check("midrst_next", 32'(out_if.digit_count), 32'd1);

    // Random keystrokes with occasional parity errors.
    for (int n = 0; n < 60; n++) begin
      r = $urandom_range(0, 9);
      case (r)
        0, 1, 2, 3, 4: b = dcodes[$urandom_range(0, 9)];
        5:             b = 8'h66;
        6:             b = 8'h76;
        7:             b = 8'hF0;
        8:             b = 8'hE0;
        default:       b = 8'($urandom);
      endcase
      send_frame(b, $urandom_range(0, 9) == 0);
      check_state("rand");
    end

    cyc(20);
    check("scan_queue_empty", 32'(exp_scan.size()), 32'd0);
    check("user_queue_empty", 32'(exp_user.size()), 32'd0);
    check("err_pending", 32'(exp_err), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
